// File: rtl/program_loader_pkg.sv
// Shared CPU package: loader widths, the sync byte and loader state encodings.
package program_loader_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_WAIT_SYNC = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_LEN   = 3'd2,
    ST_GET_DATA  = 3'd3,
    ST_GET_CSUM  = 3'd4,
    ST_RUN       = 3'd5,
    ST_ERROR     = 3'd6
  } ld_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: host byte link, memory write port and CPU control/status.
interface program_loader_if;
  import program_loader_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic              cpu_reset;
  logic              cpu_halt;
  logic              busy;
  logic              done;
  logic              err;

  // Host / system side: supplies bytes and CPU status, observes the loader.
  modport master (
    output rx_data, rx_valid, cpu_halt,
    input  rx_ready, mem_addr, mem_din, mem_we, cpu_reset, busy, done, err
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_valid, cpu_halt,
    output rx_ready, mem_addr, mem_din, mem_we, cpu_reset, busy, done, err
  );

endinterface

// File: rtl/program_loader.sv
// Program loader: receives SYNC/ADDR/LEN/DATA/CSUM frames from the host link,
// writes the payload to memory and releases the CPU on a good checksum.
module program_loader
  import program_loader_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave bus
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              rx_ready_q, rx_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept_c;
  logic [DATA_W-1:0] sum_c;
  logic              unused_halt;

  // CPU halt is status only and never steers the loader.
  assign unused_halt = bus.cpu_halt;

  assign accept_c = bus.rx_valid & rx_ready_q;
  assign sum_c    = DATA_W'(acc_q + bus.rx_data);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rx_ready_d = 1'b1;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;

    case (state_q)
      ST_WAIT_SYNC, ST_RUN, ST_ERROR: begin
        if (accept_c && (bus.rx_data == SYNC_BYTE)) begin
          state_d = ST_GET_ADDR;
        end
      end
      ST_GET_ADDR: begin
        if (accept_c) begin
          ptr_d   = ADDR_W'(bus.rx_data);
          acc_d   = bus.rx_data;
          state_d = ST_GET_LEN;
        end
      end
      ST_GET_LEN: begin
        if (accept_c) begin
          cnt_d   = bus.rx_data;
          acc_d   = sum_c;
          state_d = (bus.rx_data == '0) ? ST_GET_CSUM : ST_GET_DATA;
        end
      end
      ST_GET_DATA: begin
        if (accept_c) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q;
          mem_din_d  = bus.rx_data;
          ptr_d      = ADDR_W'(ptr_q + ADDR_W'(1));
          cnt_d      = DATA_W'(cnt_q - DATA_W'(1));
          acc_d      = sum_c;
          if (cnt_q == DATA_W'(1)) begin
            state_d = ST_GET_CSUM;
          end
        end
      end
      ST_GET_CSUM: begin
        if (accept_c) begin
          state_d = (sum_c == '0) ? ST_RUN : ST_ERROR;
        end
      end
      default: state_d = ST_WAIT_SYNC;
    endcase

    // Status outputs follow the state being entered so they line up with it.
    busy_d      = (state_d == ST_GET_ADDR) || (state_d == ST_GET_LEN) ||
                  (state_d == ST_GET_DATA) || (state_d == ST_GET_CSUM);
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_RUN);
    err_d       = (state_d == ST_ERROR);
  end

  // State, datapath and output registers; reset drops any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT_SYNC;
      ptr_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed frames, expected memory writes go
// into a scoreboard queue that a negedge monitor drains and compares.
module tb_program_loader;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  program_loader_if bus ();

  program_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         consec;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_we_cyc = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.mem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: we=%b addr=0x%0h din=0x%0h, expected no write (t=%0t)",
                 bus.mem_we, bus.mem_addr, bus.mem_din, $time);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", 32'(bus.mem_addr), 32'(w.addr));
        check("write_data", 32'(bus.mem_din), 32'(w.data));
        if (w.consec) check("write_consecutive", 32'(cyc - last_we_cyc), 32'd1);
      end
      last_we_cyc = cyc;
    end
  end

  // Present one byte, wait (bounded) for acceptance, optionally idle a cycle.
  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Everything after SYNC; expected writes are queued before sending.
  task automatic send_body(input logic [7:0] addr, input logic [7:0] len,
                           input logic [7:0] d [4], input logic [7:0] csum, input bit gap);
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back('{addr: 8'(addr + 8'(i)), data: d[i], consec: (i != 0) && !gap});
    send(addr, gap);
    send(len, gap);
    for (int i = 0; i < int'(len); i++) send(d[i], gap);
    send(csum, gap);
  endtask

  task automatic check_status(input string tag, input logic busy_e, input logic done_e,
                              input logic err_e, input logic cpu_rst_e);
    check({tag, "_busy"}, 32'(bus.busy), 32'(busy_e));
    check({tag, "_done"}, 32'(bus.done), 32'(done_e));
    check({tag, "_err"}, 32'(bus.err), 32'(err_e));
    check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(cpu_rst_e));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_din"}, 32'(bus.mem_din), 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d [4];

    reset        = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.cpu_halt = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("por");
    reset = 1'b0;
    @(posedge clk); #1;
    check("rx_ready_after_reset", 32'(bus.rx_ready), 32'd1);

    // Good frame, back-to-back: 0x10+0x03+0x11+0x22+0x33 = 0x79, CSUM 0x87.
    d = '{8'h11, 8'h22, 8'h33, 8'h00};
    send(8'hA5, 1'b0);
    check_status("f1_sync", 1'b1, 1'b0, 1'b0, 1'b1);
    send_body(8'h10, 8'h03, d, 8'h87, 1'b0);
    check_status("f1_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Noise in RUN with cpu_halt asserted: loader stays in RUN.
    bus.cpu_halt = 1'b1;
    send(8'h00, 1'b0);
    send(8'hFF, 1'b1);
    check_status("run_noise", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.cpu_halt = 1'b0;

    // SYNC in RUN aborts the CPU; same frame with a bad checksum.
    send(8'hA5, 1'b0);
    check_status("run_abort", 1'b1, 1'b0, 1'b0, 1'b1);
    send_body(8'h10, 8'h03, d, 8'h7E, 1'b0);
    check_status("f2_bad", 1'b0, 1'b0, 1'b1, 1'b1);

    // Noise in ERROR is discarded.
    send(8'h12, 1'b0);
    check_status("err_noise", 1'b0, 1'b0, 1'b1, 1'b1);

    // Pointer wrap FE,FF,00; sum 0x107 -> 0x07, CSUM 0xF9.
    d = '{8'h01, 8'h02, 8'h03, 8'h00};
    send(8'hA5, 1'b0);
    check_status("f3_sync", 1'b1, 1'b0, 1'b0, 1'b1);
    send_body(8'hFE, 8'h03, d, 8'hF9, 1'b0);
    check_status("f3_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Zero-length frame: 0x40+0x00+0xC0 = 0x100.
    send(8'hA5, 1'b0);
    send_body(8'h40, 8'h00, d, 8'hC0, 1'b0);
    check_status("f4_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset right after the second data byte: its write must be dropped.
    send(8'hA5, 1'b0);
    exp_q.push_back('{addr: 8'h10, data: 8'h11, consec: 1'b0});
    send(8'h10, 1'b0);
    send(8'h03, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset_hold");

    // SYNC presented while reset is high is not taken.
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_sync");
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check_status("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);

    // Noise then a frame with rx_valid toggling: 0x20+0x02+0xAA+0x55 = 0x121, CSUM 0xDF.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    check_status("ws_noise", 1'b0, 1'b0, 1'b0, 1'b1);
    d = '{8'hAA, 8'h55, 8'h00, 8'h00};
    send(8'hA5, 1'b1);
    send_body(8'h20, 8'h02, d, 8'hDF, 1'b1);
    check_status("f5_end", 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
